// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running VGA raster timing generator
// Pixel divider, h/v raster counters, registered video outputs and delayed syncs.
module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pixel_tick,
  output logic       toDisplay,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          div_wrap;
  logic          active;
  logic          pix_origin;
  logic          hs_int;
  logic          vs_int;

  assign div_wrap   = (div == DIV_LAST);
  assign active     = (h < H_ACT) && (v < V_ACT);
  // first clk of pixel (0,0): the divider has just wrapped into this pixel
  assign pix_origin = (div == '0) && (h == '0) && (v == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= div_wrap ? '0 : div + 1'b1;
      if (div_wrap) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_tick  <= 1'b0;
      toDisplay   <= 1'b0;
      x           <= '0;
      y           <= '0;
      hs_int      <= 1'b1;
      vs_int      <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      pixel_tick  <= div_wrap;
      toDisplay   <= active;
      x           <= active ? 10'(h) : '0;
      y           <= active ? 9'(v) : '0;
      hs_int      <= !((h >= HS_BEG) && (h <= HS_END));
      vs_int      <= !((v >= VS_BEG) && (v <= VS_END));
      frame_start <= pix_origin;
      if (pix_origin) frame_count <= frame_count + 8'd1;
    end
  end

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hsync = hs_int;
      assign vsync = vs_int;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_d;
      logic [SYNC_DELAY-1:0] vs_d;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hs_d <= '1;
          vs_d <= '1;
        end else begin
          hs_d[0] <= hs_int;
          vs_d[0] <= vs_int;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_d[i] <= hs_d[i-1];
            vs_d[i] <= vs_d[i-1];
          end
        end
      end
      assign hsync = hs_d[SYNC_DELAY-1];
      assign vsync = vs_d[SYNC_DELAY-1];
    end
  endgenerate

endmodule
